pattern_bank: RTL and testbench
===============================

PATTERN_BANK -- requirements
Module: pattern_bank

Interface
REQ-001 SHALL have parameter d_width, default 8, meaning field data width.
REQ-002 SHALL have parameter bufp_width, default 3, meaning buffer-select width (8 buffers).
REQ-003 SHALL have parameter fieldp_width, default 5, meaning field-select width (32 fields per buffer).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port buf_fieldp  input  bufp_width+fieldp_width  core read address {buf, field}.
REQ-007 SHALL have port buf_fieldwp  input  bufp_width+fieldp_width  core write address {buf, field}.
REQ-008 SHALL have port field_write_en  input  1  core write strobe.
REQ-009 SHALL have port field_in  input  d_width  core write data.
REQ-010 SHALL have port field_out  output  d_width  core read data.
REQ-011 SHALL have port load_start  input  1  one-cycle request to bulk-load a buffer.
REQ-012 SHALL have port load_buf  input  bufp_width  target buffer, sampled with load_start.
REQ-013 SHALL have port load_valid  input  1  load_data valid.
REQ-014 SHALL have port load_data  input  d_width  bulk-load data, one field per beat.
REQ-015 SHALL have port load_ready  output  1  bank accepts load_data this cycle.
REQ-016 SHALL have port load_busy  output  1  bulk load in progress.
REQ-017 SHALL have port load_done  output  1  one-cycle pulse after final beat.
REQ-018 SHALL have port buf_locked  output  1  core read address targets the buffer being loaded.

Function
REQ-019 SHALL store 2^(bufp_width+fieldp_width) words of d_width bits; storage is not reset.
REQ-020 SHALL drive field_out combinationally from storage at buf_fieldp; same-cycle write to that address not bypassed (old data shown).
REQ-021 SHALL write field_in to buf_fieldwp at the clock edge when field_write_en=1, in any state.
REQ-022 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-023 IDLE: load_start=1 -> capture load_buf into target register, beat counter=0, next LOAD; else stay.
REQ-024 LOAD: load_ready = NOT field_write_en (core write has priority; no simultaneous loader write).
REQ-025 LOAD: load_valid AND load_ready -> write load_data to {target, counter}, counter+1 (fieldp_width bits).
REQ-026 LOAD: beat accepted with counter = 2^fieldp_width-1 -> next DONE; counter wraps to 0.
REQ-027 DONE: load_done=1 for exactly this cycle; next IDLE unconditionally.
REQ-028 load_start while in LOAD or DONE SHALL be ignored (no retarget, no counter restart).
REQ-029 load_busy=1 exactly when state is LOAD; load_ready=0 outside LOAD.
REQ-030 buf_locked = (state==LOAD) AND (buf_fieldp upper bufp_width bits == target); combinational.
REQ-031 load_valid with load_ready=0 SHALL write nothing and not advance the counter; source holds data.
REQ-032 Core write into the target buffer during LOAD is permitted; a later loader beat to the same field overwrites it.

Reset
REQ-033 reset=1 at a clock edge SHALL force state IDLE, counter 0, target 0; outputs load_ready=0, load_busy=0, load_done=0, buf_locked=0.
REQ-034 reset SHALL take priority over load_start, load beats and core writes in the same cycle; storage contents retained, partial load abandoned.

Verification
REQ-035 Bulk load: load_start, load_buf=3, 32 beats data=0x40+i with load_valid=1 -> load_busy 32 cycles, load_done one cycle after last beat, reads {3,i} return 0x40+i.
REQ-036 Conflict: during load to buffer 2, field_write_en=1 at beat 5 -> load_ready=0 that cycle, beat 5 accepted next cycle, core word written, load still 32 beats.
REQ-037 Lock: load to buffer 1, buf_fieldp={1,7} -> buf_locked=1; buf_fieldp={4,7} -> buf_locked=0; after load_done, buf_locked=0.
REQ-038 Reset mid-load: reset after 10 beats into buffer 5 -> IDLE, busy=0, no load_done; fields 0..9 hold loaded data, 10..31 unchanged.
REQ-039 Ignored restart: load_start with load_buf=6 during load to buffer 0 -> target stays 0, counter continues, buffer 6 untouched.
REQ-040 Read-during-write: write 0xAA to {0,0} while buf_fieldp={0,0} (old 0x11) -> field_out 0x11 that cycle, 0xAA next cycle.

Source files
------------

// File: rtl/pattern_bank.sv
// pattern_bank: banked field storage (buffers x fields) with a single core
// read/write port and a streaming bulk loader that fills one whole buffer.
module pattern_bank #(
  parameter int d_width      = 8,
  parameter int bufp_width   = 3,
  parameter int fieldp_width = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [bufp_width+fieldp_width-1:0] buf_fieldp,
  input  logic [bufp_width+fieldp_width-1:0] buf_fieldwp,
  input  logic                               field_write_en,
  input  logic [d_width-1:0]                 field_in,
  output logic [d_width-1:0]                 field_out,
  input  logic                               load_start,
  input  logic [bufp_width-1:0]              load_buf,
  input  logic                               load_valid,
  input  logic [d_width-1:0]                 load_data,
  output logic                               load_ready,
  output logic                               load_busy,
  output logic                               load_done,
  output logic                               buf_locked
);

  localparam int AW    = bufp_width + fieldp_width;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q,  state_d;
  logic [bufp_width-1:0]   target_q, target_d;
  logic [fieldp_width-1:0] cnt_q,    cnt_d;

  logic [d_width-1:0] mem_q [DEPTH];

  logic               beat;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [d_width-1:0] wr_data;

  // Loader FSM next-state: capture target on start, count accepted beats.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    beat       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          target_d = load_buf;
          cnt_d    = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        // Core writes own the single write port; the loader backs off.
        load_ready = ~field_write_en;
        beat       = load_valid & ~field_write_en;
        if (beat) begin
          cnt_d = cnt_q + fieldp_width'(1);
          if (cnt_q == {fieldp_width{1'b1}}) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Single write port mux; reset suppresses every write in its cycle.
  always_comb begin
    wr_en   = ~reset & (field_write_en | beat);
    wr_addr = field_write_en ? buf_fieldwp : {target_q, cnt_q};
    wr_data = field_write_en ? field_in : load_data;
  end

  // Status outputs decoded from the current state.
  always_comb begin
    load_busy  = (state_q == S_LOAD);
    load_done  = (state_q == S_DONE);
    buf_locked = load_busy && (buf_fieldp[AW-1:fieldp_width] == target_q);
    field_out  = mem_q[buf_fieldp];
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_pattern_bank.sv
// Directed self-checking bench for pattern_bank (default parameters).
module tb_pattern_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] buf_fieldp, buf_fieldwp;
  logic       field_write_en;
  logic [7:0] field_in, field_out;
  logic       load_start;
  logic [2:0] load_buf;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready, load_busy, load_done, buf_locked;

  int n_chk = 0;
  int n_fail = 0;

  pattern_bank dut (
    .clk(clk), .reset(reset), .buf_fieldp(buf_fieldp), .buf_fieldwp(buf_fieldwp),
    .field_write_en(field_write_en), .field_in(field_in), .field_out(field_out),
    .load_start(load_start), .load_buf(load_buf), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_busy(load_busy),
    .load_done(load_done), .buf_locked(buf_locked)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] addr(input int b, input int f);
    logic [2:0] bb;
    logic [4:0] ff;
    bb = b[2:0];
    ff = f[4:0];
    return {bb, ff};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_write(input logic [7:0] a, input logic [7:0] d);
    buf_fieldwp = a; field_in = d; field_write_en = 1'b1;
    tick();
    field_write_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 1'b1; load_buf = 3'd4; load_valid = 1'b0; load_data = '0;
    field_write_en = 1'b0; field_in = '0; buf_fieldp = '0; buf_fieldwp = '0;
    tick(); tick();
    n_chk++; if ({load_ready, load_busy, load_done, buf_locked} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {load_ready, load_busy, load_done, buf_locked});
    end
    reset = 1'b0; load_start = 1'b0;
    #1;
    n_chk++; if (load_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_beats_start: busy=%b expected 0", load_busy);
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) core_write(addr(5, i), 8'(8'h80 + i));
    for (int i = 0; i < 32; i++) core_write(addr(6, i), 8'(8'h60 + i));
  endtask

  // Full load to buffer 3 with one load_valid gap at beat 16.
  task automatic test_bulk_load();
    int busy_cnt;
    busy_cnt = 0;
    load_start = 1'b1; load_buf = 3'd3; tick(); load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) begin
        load_valid = 1'b0; load_data = 8'hFF; #1;
        if (load_busy) busy_cnt++;
        tick();
      end
      load_valid = 1'b1; load_data = 8'(8'h40 + i); #1;
      if (load_busy) busy_cnt++;
      n_chk++; if (load_ready !== 1'b1) begin
        n_fail++; $display("FAIL bulk_ready beat %0d: got %b expected 1", i, load_ready);
      end
      tick();
    end
    load_valid = 1'b0; #1;
    n_chk++; if ({load_done, load_busy, load_ready} !== 3'b100) begin
      n_fail++; $display("FAIL bulk_done: done/busy/ready=%b expected 100", {load_done, load_busy, load_ready});
    end
    // 32 beats plus the one stall cycle.
    n_chk++; if (busy_cnt !== 33) begin
      n_fail++; $display("FAIL bulk_busy_cycles: got %0d expected 33", busy_cnt);
    end
    tick();
    n_chk++; if (load_done !== 1'b0) begin
      n_fail++; $display("FAIL bulk_done_pulse: got %b expected 0", load_done);
    end
    for (int i = 0; i < 32; i++) begin
      buf_fieldp = addr(3, i); #1;
      n_chk++; if (field_out !== 8'(8'h40 + i)) begin
        n_fail++; $display("FAIL bulk_read f%0d: got %h expected %h", i, field_out, 8'(8'h40 + i));
      end
    end
  endtask

  // Core write into the target at beat 5 stalls the loader one cycle.
  task automatic test_conflict();
    load_start = 1'b1; load_buf = 3'd2; tick(); load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin
        load_valid = 1'b1; load_data = 8'h25;
        buf_fieldwp = addr(2, 20); field_in = 8'hEE; field_write_en = 1'b1; #1;
        n_chk++; if (load_ready !== 1'b0) begin
          n_fail++; $display("FAIL conflict_ready: got %b expected 0", load_ready);
        end
        tick();
        field_write_en = 1'b0;
      end
      if (i == 6) begin
        buf_fieldp = addr(2, 20); #1;
        n_chk++; if (field_out !== 8'hEE) begin
          n_fail++; $display("FAIL conflict_core_word: got %h expected ee", field_out);
        end
      end
      load_valid = 1'b1; load_data = 8'(8'h20 + i); #1;
      n_chk++; if ({load_busy, load_ready} !== 2'b11) begin
        n_fail++; $display("FAIL conflict_beat %0d: busy/ready=%b expected 11", i, {load_busy, load_ready});
      end
      tick();
    end
    load_valid = 1'b0; #1;
    n_chk++; if (load_done !== 1'b1) begin
      n_fail++; $display("FAIL conflict_done: got %b expected 1", load_done);
    end
    tick();
    for (int i = 0; i < 32; i++) begin
      buf_fieldp = addr(2, i); #1;
      n_chk++; if (field_out !== 8'(8'h20 + i)) begin
        n_fail++; $display("FAIL conflict_read f%0d: got %h expected %h", i, field_out, 8'(8'h20 + i));
      end
    end
  endtask

  task automatic test_lock();
    load_start = 1'b1; load_buf = 3'd1; tick(); load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i == 7) begin
        buf_fieldp = addr(1, 7); #1;
        n_chk++; if (buf_locked !== 1'b1) begin
          n_fail++; $display("FAIL lock_hit: got %b expected 1", buf_locked);
        end
        buf_fieldp = addr(4, 7); #1;
        n_chk++; if (buf_locked !== 1'b0) begin
          n_fail++; $display("FAIL lock_miss: got %b expected 0", buf_locked);
        end
      end
      load_valid = 1'b1; load_data = 8'(8'h10 + i); tick();
    end
    load_valid = 1'b0; buf_fieldp = addr(1, 7); #1;
    n_chk++; if ({load_done, buf_locked} !== 2'b10) begin
      n_fail++; $display("FAIL lock_at_done: done/locked=%b expected 10", {load_done, buf_locked});
    end
    tick();
    n_chk++; if (buf_locked !== 1'b0) begin
      n_fail++; $display("FAIL lock_idle: got %b expected 0", buf_locked);
    end
  endtask

  task automatic test_ignored_restart();
    load_start = 1'b1; load_buf = 3'd0; tick(); load_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      load_start = (i == 3); load_buf = 3'd6;
      if (i == 4) begin
        buf_fieldp = addr(0, 9); #1;
        n_chk++; if (buf_locked !== 1'b1) begin
          n_fail++; $display("FAIL restart_target0: got %b expected 1", buf_locked);
        end
        buf_fieldp = addr(6, 9); #1;
        n_chk++; if (buf_locked !== 1'b0) begin
          n_fail++; $display("FAIL restart_target6: got %b expected 0", buf_locked);
        end
      end
      load_valid = 1'b1; load_data = 8'(8'h70 + i); tick();
    end
    load_start = 1'b0; load_valid = 1'b0; #1;
    n_chk++; if (load_done !== 1'b1) begin
      n_fail++; $display("FAIL restart_done: got %b expected 1", load_done);
    end
    tick();
    for (int i = 0; i < 32; i++) begin
      buf_fieldp = addr(0, i); #1;
      n_chk++; if (field_out !== 8'(8'h70 + i)) begin
        n_fail++; $display("FAIL restart_buf0 f%0d: got %h expected %h", i, field_out, 8'(8'h70 + i));
      end
      buf_fieldp = addr(6, i); #1;
      n_chk++; if (field_out !== 8'(8'h60 + i)) begin
        n_fail++; $display("FAIL restart_buf6 f%0d: got %h expected %h", i, field_out, 8'(8'h60 + i));
      end
    end
  endtask

  // Reset after 10 beats, with a beat, core write and start all pending.
  task automatic test_reset_midload();
    load_start = 1'b1; load_buf = 3'd5; tick(); load_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1; load_data = 8'(8'hC0 + i); tick();
    end
    reset = 1'b1; load_data = 8'hCA; load_start = 1'b1; load_buf = 3'd2;
    buf_fieldwp = addr(5, 20); field_in = 8'hFF; field_write_en = 1'b1;
    tick();
    reset = 1'b0; load_valid = 1'b0; load_start = 1'b0; field_write_en = 1'b0;
    buf_fieldp = addr(5, 0); #1;
    n_chk++; if ({load_busy, load_ready, load_done, buf_locked} !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected 0000", {load_busy, load_ready, load_done, buf_locked});
    end
    tick();
    n_chk++; if ({load_busy, load_done} !== 2'b00) begin
      n_fail++; $display("FAIL midreset_no_done: busy/done=%b expected 00", {load_busy, load_done});
    end
    for (int i = 0; i < 32; i++) begin
      buf_fieldp = addr(5, i); #1;
      n_chk++; if (field_out !== ((i < 10) ? 8'(8'hC0 + i) : 8'(8'h80 + i))) begin
        n_fail++; $display("FAIL midreset_read f%0d: got %h expected %h", i, field_out,
                           (i < 10) ? 8'(8'hC0 + i) : 8'(8'h80 + i));
      end
    end
  endtask

  task automatic test_read_during_write();
    core_write(addr(0, 0), 8'h11);
    buf_fieldp = addr(0, 0);
    buf_fieldwp = addr(0, 0); field_in = 8'hAA; field_write_en = 1'b1; #1;
    n_chk++; if (field_out !== 8'h11) begin
      n_fail++; $display("FAIL rdw_old: got %h expected 11", field_out);
    end
    tick();
    field_write_en = 1'b0; #1;
    n_chk++; if (field_out !== 8'hAA) begin
      n_fail++; $display("FAIL rdw_new: got %h expected aa", field_out);
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_bulk_load();
    test_conflict();
    test_lock();
    test_ignored_restart();
    test_reset_midload();
    test_read_during_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
